exc_flush_ctrl: RTL and testbench

- Exception/interrupt controller for the M-stage pipeline register (CP0-style).
- Each cycle: collects the M-stage exception flags and the hardware interrupt lines, prioritises them, and raises Req to flush every pipeline register and redirect fetch to the handler.
- Holds the SR, Cause, EPC and BadVAddr state and sequences the RUN/EXC (EXL) mode.
- Serves mfc0/mtc0 and produces the eret redirect.

---
 rtl/cp0_pkg.sv | 31 +++
 rtl/exc_prio_enc.sv | 30 +++
 rtl/exc_flush_ctrl.sv | 153 +++++++++++++++
 tb/tb_exc_flush_ctrl.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: exception codes, register numbers, field positions
// and the default handler entry point for the exception/flush controller.
package cp0_pkg;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam logic [4:0] CP0_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_SR       = 5'd12;
  localparam logic [4:0] CP0_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_EPC      = 5'd14;

  localparam int unsigned SR_IE        = 0;
  localparam int unsigned SR_EXL       = 1;
  localparam int unsigned SR_IM_LO     = 10;
  localparam int unsigned CAUSE_EXC_LO = 2;
  localparam int unsigned CAUSE_IP_LO  = 10;
  localparam int unsigned CAUSE_BD     = 31;

  localparam logic [31:0] HANDLER_PC_DEF = 32'h0000_4180;

  typedef enum logic {
    ST_RUN = 1'b0,
    ST_EXC = 1'b1
  } mode_e;

endpackage

// File: rtl/exc_prio_enc.sv
// Fixed-priority encoder: pending interrupt and M-stage exception flags
// reduced to a valid bit and the winning ExcCode.
module exc_prio_enc
  import cp0_pkg::*;
(
  input  logic       int_i,
  input  logic       adel1_i,
  input  logic       ri_i,
  input  logic       sys_i,
  input  logic       ov_i,
  input  logic       adel2_i,
  input  logic       ades_i,
  output logic       valid_o,
  output logic [4:0] code_o
);

  always_comb begin
    valid_o = 1'b1;
    code_o  = EXC_INT;
    if (int_i)        code_o = EXC_INT;
    else if (adel1_i) code_o = EXC_ADEL;
    else if (ri_i)    code_o = EXC_RI;
    else if (sys_i)   code_o = EXC_SYS;
    else if (ov_i)    code_o = EXC_OV;
    else if (adel2_i) code_o = EXC_ADEL;
    else if (ades_i)  code_o = EXC_ADES;
    else              valid_o = 1'b0;
  end

endmodule

// File: rtl/exc_flush_ctrl.sv
// CP0-style exception/interrupt controller for the M stage: flush request,
// SR/Cause/EPC state, mfc0/mtc0 and eret. BadVAddr exists only with BADVADDR_EN.
module exc_flush_ctrl
  import cp0_pkg::*;
#(
  parameter logic [31:0] HANDLER_PC = HANDLER_PC_DEF,
  parameter logic [5:0]  IM_RESET   = 6'b000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] MEMPC,
  input  logic        MEMValid,
  input  logic        MEMBD,
  input  logic        MEMAdEL_1,
  input  logic        MEMAdEL_2,
  input  logic        MEMAdES,
  input  logic        MEMOv,
  input  logic        MEMRI,
  input  logic        MEMSyscall,
  input  logic [31:0] MEMALUOut,
  input  logic        MEMEret,
  input  logic        CP0We,
  input  logic [4:0]  CP0Addr,
  input  logic [31:0] CP0WD,
  input  logic [5:0]  HWInt,
  output logic [31:0] CP0RD,
  output logic        Req,
  output logic        EretRedirect,
  output logic [31:0] EPCOut,
  output logic        EXL
);

  mode_e       mode_q, mode_d;
  logic [5:0]  im_q, im_d, ip_q;
  logic        ie_q, ie_d, bd_q, bd_d;
  logic [4:0]  code_q, code_d;
  logic [31:0] epc_q, epc_d;

  logic        exl, int_pend, enc_valid, req, eret, mtc0;
  logic [4:0]  enc_code;
  logic [31:0] sr_word, cause_word, badv_word;

  // The handler address is applied by the fetch redirect mux outside this block.
  logic unused_handler_pc;
  assign unused_handler_pc = ^HANDLER_PC;

  assign exl      = (mode_q == ST_EXC);
  assign int_pend = (|(HWInt & im_q)) & ie_q;

  exc_prio_enc u_enc (
    .int_i   (int_pend),
    .adel1_i (MEMAdEL_1),
    .ri_i    (MEMRI),
    .sys_i   (MEMSyscall),
    .ov_i    (MEMOv),
    .adel2_i (MEMAdEL_2),
    .ades_i  (MEMAdES),
    .valid_o (enc_valid),
    .code_o  (enc_code)
  );

  assign req  = ~reset & ~exl & MEMValid & enc_valid;
  assign eret = ~reset & exl & MEMValid & MEMEret;
  assign mtc0 = CP0We & MEMValid & ~req;

  always_comb begin
    mode_d = mode_q;
    im_d   = im_q;
    ie_d   = ie_q;
    bd_d   = bd_q;
    code_d = code_q;
    epc_d  = epc_q;
    // Exception entry overrides any mtc0 issued by the same instruction.
    if (req) begin
      mode_d = ST_EXC;
      code_d = enc_code;
      bd_d   = MEMBD;
      epc_d  = MEMBD ? (MEMPC - 32'd4) : MEMPC;
    end else begin
      if (eret) mode_d = ST_RUN;
      if (mtc0 && (CP0Addr == CP0_SR)) begin
        im_d   = CP0WD[SR_IM_LO +: 6];
        ie_d   = CP0WD[SR_IE];
        mode_d = mode_e'(CP0WD[SR_EXL]);
      end
      if (mtc0 && (CP0Addr == CP0_EPC)) epc_d = CP0WD;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q <= ST_RUN;
      im_q   <= IM_RESET;
      ie_q   <= 1'b0;
      bd_q   <= 1'b0;
      ip_q   <= '0;
      code_q <= '0;
      epc_q  <= '0;
    end else begin
      mode_q <= mode_d;
      im_q   <= im_d;
      ie_q   <= ie_d;
      bd_q   <= bd_d;
      ip_q   <= HWInt;
      code_q <= code_d;
      epc_q  <= epc_d;
    end
  end

`ifdef BADVADDR_EN
  logic [31:0] badv_q;
  always_ff @(posedge clk) begin
    if (reset) badv_q <= '0;
    else if (req && (enc_code == EXC_ADEL) && MEMAdEL_1) badv_q <= MEMPC;
    else if (req && ((enc_code == EXC_ADEL) || (enc_code == EXC_ADES))) badv_q <= MEMALUOut;
  end
  assign badv_word = badv_q;
`else
  logic unused_aluout;
  assign unused_aluout = ^MEMALUOut;
  assign badv_word     = '0;
`endif

  always_comb begin
    sr_word                          = '0;
    sr_word[SR_IM_LO +: 6]           = im_q;
    sr_word[SR_EXL]                  = exl;
    sr_word[SR_IE]                   = ie_q;
    cause_word                       = '0;
    cause_word[CAUSE_BD]             = bd_q;
    cause_word[CAUSE_IP_LO +: 6]     = ip_q;
    cause_word[CAUSE_EXC_LO +: 5]    = code_q;
  end

  always_comb begin
    CP0RD = '0;
    if (!reset) begin
      case (CP0Addr)
        CP0_BADVADDR: CP0RD = badv_word;
        CP0_SR:       CP0RD = sr_word;
        CP0_CAUSE:    CP0RD = cause_word;
        CP0_EPC:      CP0RD = epc_q;
        default:      CP0RD = '0;
      endcase
    end
  end

  assign Req          = req;
  assign EretRedirect = eret;
  assign EPCOut       = reset ? '0 : epc_q;
  assign EXL          = exl;

endmodule

// File: tb/tb_exc_flush_ctrl.sv
// Scoreboard bench for exc_flush_ctrl; define BADVADDR_EN to also check BadVAddr.
module tb_exc_flush_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] MEMPC, MEMALUOut, CP0WD, CP0RD, EPCOut;
  logic        MEMValid, MEMBD, MEMAdEL_1, MEMAdEL_2, MEMAdES, MEMOv, MEMRI, MEMSyscall;
  logic        MEMEret, CP0We, Req, EretRedirect, EXL;
  logic [4:0]  CP0Addr;
  logic [5:0]  HWInt;

  exc_flush_ctrl #(.HANDLER_PC(32'h0000_4180), .IM_RESET(6'b000000)) dut (
    .clk(clk), .reset(reset), .MEMPC(MEMPC), .MEMValid(MEMValid), .MEMBD(MEMBD),
    .MEMAdEL_1(MEMAdEL_1), .MEMAdEL_2(MEMAdEL_2), .MEMAdES(MEMAdES), .MEMOv(MEMOv),
    .MEMRI(MEMRI), .MEMSyscall(MEMSyscall), .MEMALUOut(MEMALUOut), .MEMEret(MEMEret),
    .CP0We(CP0We), .CP0Addr(CP0Addr), .CP0WD(CP0WD), .HWInt(HWInt), .CP0RD(CP0RD),
    .Req(Req), .EretRedirect(EretRedirect), .EPCOut(EPCOut), .EXL(EXL)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } exp_t;

  typedef struct {
    logic        hw;
    logic [5:0]  fl;   // {adel1, adel2, ades, ov, ri, sys}
    logic        bd;
    logic [31:0] pc;
    logic [31:0] alu;
    logic [4:0]  code;
  } prio_t;

  exp_t        sb[$];
  logic [31:0] obs_q[$];
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  logic [31:0] badv_model = '0;

  task automatic push(input string n, input logic [31:0] v);
    sb.push_back('{n, v});
  endtask

  task automatic observe(input logic [31:0] v);
    obs_q.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    MEMValid = 0; MEMBD = 0; MEMAdEL_1 = 0; MEMAdEL_2 = 0; MEMAdES = 0; MEMOv = 0;
    MEMRI = 0; MEMSyscall = 0; MEMEret = 0; CP0We = 0; CP0Addr = '0; CP0WD = '0;
    HWInt = '0; MEMPC = '0; MEMALUOut = '0;
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] d);
    CP0Addr = a;
    #1;
    d = CP0RD;
  endtask

  task automatic test_reset();
    logic [31:0] d, o;
    exp_t e;
    idle();
    reset = 1;
    tick();
    MEMValid = 1; MEMSyscall = 1; HWInt = '1; MEMEret = 1; CP0Addr = 5'd12;
    push("rst_req", 0); push("rst_eret", 0); push("rst_rd", 0); push("rst_epcout", 0);
    #1;
    observe({31'b0, Req}); observe({31'b0, EretRedirect}); observe(CP0RD); observe(EPCOut);
    tick();
    reset = 0;
    idle();
    push("rst_sr", 0); push("rst_cause", 0); push("rst_epc", 0); push("rst_req_after", 0);
    push("rst_exl", 0);
    rd(5'd12, d); observe(d);
    rd(5'd13, d); observe(d);
    rd(5'd14, d); observe(d);
    observe({31'b0, Req}); observe({31'b0, EXL});
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
      n_cmp++;
      if (o !== e.exp) begin n_bad++; $display("FAIL %s: got %h expected %h", e.name, o, e.exp); end
    end
  endtask

  task automatic test_interrupt();
    logic [31:0] d, o;
    exp_t e;
    idle(); MEMValid = 1; CP0We = 1; CP0Addr = 5'd12; CP0WD = 32'h0000_0401;
    tick(); idle();
    push("int_sr_written", 32'h0000_0401);
    rd(5'd12, d); observe(d);
    HWInt = 6'b000001; MEMValid = 1; MEMPC = 32'h3010;
    push("int_req", 1);
    #1; observe({31'b0, Req});
    tick(); idle();
    push("int_exl", 1); push("int_cause", 32'h0000_0400); push("int_epc", 32'h3010);
    push("int_sr_exl", 32'h0000_0403);
    observe({31'b0, EXL});
    rd(5'd13, d); observe(d);
    rd(5'd14, d); observe(d);
    rd(5'd12, d); observe(d);
    MEMEret = 1; MEMValid = 1;
    push("int_eret", 1); push("int_eret_pc", 32'h3010); push("int_eret_noreq", 0);
    #1; observe({31'b0, EretRedirect}); observe(EPCOut); observe({31'b0, Req});
    tick(); idle();
    push("int_exl_clear", 0); push("int_cause_ip_clear", 0);
    observe({31'b0, EXL});
    rd(5'd13, d); observe(d);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
      n_cmp++;
      if (o !== e.exp) begin n_bad++; $display("FAIL %s: got %h expected %h", e.name, o, e.exp); end
    end
  endtask

  task automatic test_exception_in_exl();
    logic [31:0] d, o;
    exp_t e;
    idle(); MEMOv = 1; MEMBD = 1; MEMPC = 32'h3024; MEMValid = 1;
    push("ov_req", 1);
    #1; observe({31'b0, Req});
    tick(); idle();
    push("ov_epc", 32'h3020); push("ov_cause", 32'h8000_0030);
    rd(5'd14, d); observe(d);
    rd(5'd13, d); observe(d);
    MEMSyscall = 1; MEMValid = 1; MEMPC = 32'h3050;
    push("exl_sys_noreq", 0);
    #1; observe({31'b0, Req});
    tick(); idle();
    push("exl_cause_kept", 32'h8000_0030); push("exl_epc_kept", 32'h3020);
    rd(5'd13, d); observe(d);
    rd(5'd14, d); observe(d);
    MEMEret = 1; MEMValid = 1;
    push("exl_eret", 1); push("exl_eret_pc", 32'h3020);
    #1; observe({31'b0, EretRedirect}); observe(EPCOut);
    tick(); idle();
    push("exl_cleared", 0);
    observe({31'b0, EXL});
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
      n_cmp++;
      if (o !== e.exp) begin n_bad++; $display("FAIL %s: got %h expected %h", e.name, o, e.exp); end
    end
  endtask

  task automatic test_priority();
    prio_t       tbl[7];
    logic [31:0] d, o;
    exp_t        e;
    tbl[0] = '{1'b0, 6'b000011 | 6'b010000, 1'b0, 32'h3100, 32'h5555, 5'd10};
    tbl[1] = '{1'b0, 6'b100010, 1'b1, 32'h3204, 32'h6000, 5'd4};
    tbl[2] = '{1'b0, 6'b000101, 1'b0, 32'h3300, 32'h0000, 5'd8};
    tbl[3] = '{1'b0, 6'b001000, 1'b0, 32'h3400, 32'h2003, 5'd5};
    tbl[4] = '{1'b0, 6'b011000, 1'b0, 32'h3500, 32'h7000, 5'd4};
    tbl[5] = '{1'b0, 6'b010100, 1'b0, 32'h3600, 32'h8000, 5'd12};
    tbl[6] = '{1'b1, 6'b100000, 1'b0, 32'h3700, 32'h9000, 5'd0};
    tbl[0].fl = 6'b010010;
    foreach (tbl[i]) begin
      idle();
      HWInt = {5'b0, tbl[i].hw}; MEMValid = 1; MEMBD = tbl[i].bd; MEMPC = tbl[i].pc;
      MEMALUOut = tbl[i].alu;
      {MEMAdEL_1, MEMAdEL_2, MEMAdES, MEMOv, MEMRI, MEMSyscall} = tbl[i].fl;
      if (tbl[i].hw) ;
      else if (tbl[i].fl[5]) badv_model = tbl[i].pc;
      else if (|tbl[i].fl[2:0]) ;
      else if (|tbl[i].fl[4:3]) badv_model = tbl[i].alu;
      push($sformatf("prio%0d_req", i), 1);
      #1; observe({31'b0, Req});
      tick(); idle();
      push($sformatf("prio%0d_cause", i),
           ({31'b0, tbl[i].bd} << 31) | ({31'b0, tbl[i].hw} << 10) | ({27'b0, tbl[i].code} << 2));
      push($sformatf("prio%0d_epc", i), tbl[i].bd ? tbl[i].pc - 32'd4 : tbl[i].pc);
`ifdef BADVADDR_EN
      push($sformatf("prio%0d_badv", i), badv_model);
`else
      push($sformatf("prio%0d_badv", i), 0);
`endif
      rd(5'd13, d); observe(d);
      rd(5'd14, d); observe(d);
      rd(5'd8, d);  observe(d);
      MEMEret = 1; MEMValid = 1;
      tick(); idle();
      push($sformatf("prio%0d_exl_clear", i), 0);
      observe({31'b0, EXL});
      while (sb.size() > 0) begin
        e = sb.pop_front();
        o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
        n_cmp++;
        if (o !== e.exp) begin n_bad++; $display("FAIL %s: got %h expected %h", e.name, o, e.exp); end
      end
    end
  endtask

  task automatic test_bubble();
    logic [31:0] d, o;
    exp_t e;
    idle(); HWInt = 6'b000001; MEMValid = 0; MEMPC = 32'h3800;
    push("bub_noreq", 0);
    #1; observe({31'b0, Req});
    tick();
    push("bub_exl_still0", 0); push("bub_valid_req", 1);
    observe({31'b0, EXL});
    MEMValid = 1;
    #1; observe({31'b0, Req});
    tick(); idle();
    push("bub_exl", 1); push("bub_epc", 32'h3800);
    observe({31'b0, EXL});
    rd(5'd14, d); observe(d);
    MEMEret = 1; MEMValid = 1;
    tick(); idle();
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
      n_cmp++;
      if (o !== e.exp) begin n_bad++; $display("FAIL %s: got %h expected %h", e.name, o, e.exp); end
    end
  endtask

  task automatic test_mtc0();
    logic [31:0] d, o;
    exp_t e;
    idle(); MEMValid = 1; CP0We = 1; CP0Addr = 5'd14; CP0WD = 32'h1234_5678;
    tick(); idle();
    push("mtc0_epc", 32'h1234_5678); push("mtc0_unmapped_rd", 0);
    rd(5'd14, d); observe(d);
    rd(5'd3, d);  observe(d);
    MEMValid = 1; CP0We = 1; CP0Addr = 5'd13; CP0WD = 32'hFFFF_FFFF;
    tick(); idle();
    push("mtc0_cause_ro", 0);
    rd(5'd13, d); observe(d);
    MEMValid = 1; CP0We = 1; CP0Addr = 5'd12; CP0WD = 32'h0000_0403;
    tick(); idle();
    push("mtc0_set_exl", 1); push("mtc0_exl_blocks", 0);
    observe({31'b0, EXL});
    MEMValid = 1; MEMSyscall = 1;
    #1; observe({31'b0, Req});
    tick(); idle();
    MEMValid = 1; CP0We = 1; CP0Addr = 5'd12; CP0WD = 32'h0000_0401;
    tick(); idle();
    MEMValid = 1; MEMSyscall = 1; MEMPC = 32'h3900;
    CP0We = 1; CP0Addr = 5'd14; CP0WD = 32'hDEAD_0000;
    push("coll_req", 1);
    #1; observe({31'b0, Req});
    tick(); idle();
    push("coll_epc", 32'h3900); push("coll_cause", 32'h0000_0020);
    rd(5'd14, d); observe(d);
    rd(5'd13, d); observe(d);
    reset = 1;
    tick();
    reset = 0;
    push("midreset_exl", 0); push("midreset_sr", 0);
    observe({31'b0, EXL});
    rd(5'd12, d); observe(d);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
      n_cmp++;
      if (o !== e.exp) begin n_bad++; $display("FAIL %s: got %h expected %h", e.name, o, e.exp); end
    end
  endtask

  initial begin
    test_reset();
    test_interrupt();
    test_exception_in_exl();
    test_priority();
    test_bubble();
    test_mtc0();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
